inert_spi_slave: RTL and testbench
==================================

Name: inert_spi_slave

Overview:
- SPI responder that emulates the inertial sensor seen by the inertial SPI master interface.
- Decodes 16-bit frames and holds a small configuration register file.
- Latches parallel roll/yaw/AY/AZ samples into readable data registers and raises INT when a new sample is ready.
- Used as a synthesizable sensor stand-in for FPGA bring-up and for full-chip simulation.

Parameters:
- SYNC_STAGES, 2, number of clk flops synchronizing SS_n/SCLK/MOSI (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- SS_n  in  1  active-low frame select from master.
- SCLK  in  1  serial clock from master; idles high.
- MOSI  in  1  serial data from master, MSB first.
- MISO  out  1  serial data to master.
- INT  out  1  new-sample-ready interrupt.
- roll_rt_in  in  16  roll rate sample.
- yaw_rt_in  in  16  yaw rate sample.
- AY_in  in  16  Y acceleration sample.
- AZ_in  in  16  Z acceleration sample.
- smpl_vld  in  1  one-cycle strobe: sample inputs are valid.
- overrun  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset: all registers 0x00; INT=0, MISO=0, overrun=0, FSM=IDLE, bit count=0.
- Inputs: SS_n/SCLK/MOSI pass through SYNC_STAGES flops, then one more flop for edge detect. Requires SCLK period ≥8 clk.
- SPI mode 3:
  - Sample MOSI on the synchronized SCLK rise.
  - Update MISO on the synchronized SCLK fall.
- Frame format: 16 bits.
  - cmd[15]=1 is a read, 0 is a write.
  - cmd[14:8] is the address.
  - cmd[7:0] is write data (ignored on a read).
- FSM:
  - IDLE → CMD on SS_n fall. Bit count cleared; MISO=0.
  - CMD: shift in 8 bits. On the 8th rise, decode R/W and address. On a read, load tx_shift with register data → DATA.
  - DATA: shift in bits 8–15. On each fall, MISO=tx_shift[7], then shift left.
  - Any state → IDLE on SS_n rise. If exactly 16 bits were received, commit in the cycle after the rise is detected:
    - Write: store data at a mapped address.
    - Read of 0x2D: clear INT.
  - Bit count ≠16 at SS_n rise: frame aborted, no side effects.
- Register map:
  - Config registers (R/W): 0x0D INT_CFG, 0x10 CTRL1, 0x11 CTRL2, 0x14 CTRL3.
  - Data registers (RO): 0x24/0x25 roll L/H, 0x26/0x27 yaw L/H, 0x2A/0x2B AY L/H, 0x2C/0x2D AZ L/H.
  - Unmapped reads return 0x00; unmapped writes are ignored.
- Sampling armed when INT_CFG[1]=1, CTRL1≠0 and CTRL2≠0.
- smpl_vld while armed:
  - INT=0: copy all four inputs into the data registers; INT=1 on the next clk.
  - INT=1: drop the sample and set overrun (sticky until rst).
- smpl_vld while not armed: ignored.
- Simultaneous smpl_vld and a 0x2D read commit: commit first (INT clears), then accept the sample (INT=1 next cycle). No overrun in this case.
- Data registers stay frozen while INT=1, so a burst read of the data registers is coherent.
- rst mid-frame: everything returns to reset values. The remainder of the frame is ignored until the next SS_n fall.

Decomposition:
- Package inert_spi_pkg: register address localparams, read bit position, state_t enum {IDLE, CMD, DATA}.
- Sub-module spi_slv_shift holds the synchronizers, edge detect, rx/tx shift registers, bit counter and frame_done/frame_abort strobes.
- Top level holds the register file, sample latch, INT and overrun logic.

Test Plan:
- Write frames 0x0D02, 0x1053, 0x1150, 0x1460, then read frame 0x8D00 → MISO second byte 0x02; INT remains 0.
- Arm sensor, pulse smpl_vld with roll=0x1234, yaw=0xABCD, AY=0x0F00, AZ=0x8001 → INT=1 one clk later.
- Read frames 0xA4, 0xA5, 0xA6, 0xA7, 0xAA, 0xAB, 0xAC, 0xAD → bytes 34,12,CD,AB,00,0F,01,80. INT falls the cycle after the 0xAD frame's SS_n rise.
- With INT=1, pulse smpl_vld with new data → overrun=1 and data unchanged (0xA4 still reads 0x34). Pulse smpl_vld concurrent with the 0xAD commit → INT stays 1 and overrun does not set.
- Frame 0x0D00 aborted after 10 bits → INT_CFG still 0x02 and a later smpl_vld still fires INT. Read 0xFF00 (unmapped) → 0x00.
- Assert rst in the middle of a write to 0x10 → all registers 0x00, MISO=0, and the next full frame decodes correctly.

Source files
------------

// File: rtl/inert_spi_pkg.sv
// Shared constants and types for the inertial-sensor SPI responder.
package inert_spi_pkg;

    // Register addresses (7-bit address field of the command byte)
    localparam logic [6:0] ADDR_INT_CFG = 7'h0D;
    localparam logic [6:0] ADDR_CTRL1   = 7'h10;
    localparam logic [6:0] ADDR_CTRL2   = 7'h11;
    localparam logic [6:0] ADDR_CTRL3   = 7'h14;
    localparam logic [6:0] ADDR_ROLL_L  = 7'h24;
    localparam logic [6:0] ADDR_ROLL_H  = 7'h25;
    localparam logic [6:0] ADDR_YAW_L   = 7'h26;
    localparam logic [6:0] ADDR_YAW_H   = 7'h27;
    localparam logic [6:0] ADDR_AY_L    = 7'h2A;
    localparam logic [6:0] ADDR_AY_H    = 7'h2B;
    localparam logic [6:0] ADDR_AZ_L    = 7'h2C;
    localparam logic [6:0] ADDR_AZ_H    = 7'h2D;

    // Frame layout
    localparam int unsigned READ_BIT   = 15;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CMD_BITS   = 8;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

endpackage

// File: rtl/inert_spi_slave_if.sv
// SPI pins plus the parallel sample bus of the sensor stand-in.
interface inert_spi_slave_if;

    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        INT;
    logic [15:0] roll_rt_in;
    logic [15:0] yaw_rt_in;
    logic [15:0] AY_in;
    logic [15:0] AZ_in;
    logic        smpl_vld;
    logic        overrun;

    modport master (
        output SS_n, SCLK, MOSI, roll_rt_in, yaw_rt_in, AY_in, AZ_in, smpl_vld,
        input  MISO, INT, overrun
    );

    modport slave (
        input  SS_n, SCLK, MOSI, roll_rt_in, yaw_rt_in, AY_in, AZ_in, smpl_vld,
        output MISO, INT, overrun
    );

endinterface

// File: rtl/spi_slv_shift.sv
// SPI mode-3 frame engine: input synchronizers, edge detect, shift registers,
// bit counter and end-of-frame strobes.
module spi_slv_shift
    import inert_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss_n_i,
    input  logic        sclk_i,
    input  logic        mosi_i,
    input  logic [7:0]  rd_data_i,
    output logic [6:0]  rd_addr_o,
    output logic        miso_o,
    output logic [15:0] frame_o,
    output logic        frame_done_o,
    output logic        frame_abort_o
);

    localparam logic [4:0] FrameCnt = 5'(FRAME_BITS);
    localparam logic [4:0] LastCmd  = 5'(CMD_BITS - 1);

    logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   ss_dly_q, sclk_dly_q;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    // Synchronizer chains plus one delay flop for edge detection. SS_n resets
    // to the asserted level so a frame in flight during reset is never re-entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_q   <= '0;
            sclk_sync_q <= '1;
            mosi_sync_q <= '0;
            ss_dly_q    <= 1'b0;
            sclk_dly_q  <= 1'b1;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            ss_dly_q    <= ss_s;
            sclk_dly_q  <= sclk_s;
        end
    end

    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_fall   = ss_dly_q & ~ss_s;
    assign ss_rise   = ~ss_dly_q & ss_s;
    assign sclk_rise = ~sclk_dly_q & sclk_s;
    assign sclk_fall = sclk_dly_q & ~sclk_s;

    // Frame FSM and shift-register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            miso_q  <= miso_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // Address of the command byte as it completes on the 8th rise.
    assign rd_addr_o = {rx_q[5:0], mosi_s};

    // Next-state: SS_n edges dominate, otherwise shift on SCLK edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        miso_d  = miso_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (ss_rise) begin
            state_d = IDLE;
            if (state_q != IDLE) begin
                done_d  = (cnt_q == FrameCnt);
                abort_d = (cnt_q != FrameCnt);
            end
        end else if (ss_fall) begin
            state_d = CMD;
            cnt_d   = '0;
            miso_d  = 1'b0;
            tx_d    = '0;
        end else begin
            unique case (state_q)
                CMD: begin
                    if (sclk_rise) begin
                        rx_d  = {rx_q[14:0], mosi_s};
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == LastCmd) begin
                            state_d = DATA;
                            // rx_q[6] becomes the R/W bit once this bit shifts in
                            tx_d = rx_q[6] ? rd_data_i : 8'h00;
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise && cnt_q != 5'h1F) begin
                        rx_d  = {rx_q[14:0], mosi_s};
                        cnt_d = cnt_q + 5'd1;
                    end
                    if (sclk_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign miso_o        = miso_q;
    assign frame_o       = rx_q;
    assign frame_done_o  = done_q;
    assign frame_abort_o = abort_q;

endmodule

// File: rtl/inert_spi_slave.sv
// Inertial-sensor SPI stand-in: config registers, sample latch, INT and overrun.
module inert_spi_slave
    import inert_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    inert_spi_slave_if.slave  bus
);

    logic [7:0]  int_cfg_q, int_cfg_d, ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d, ctrl3_q, ctrl3_d;
    logic [15:0] roll_q, roll_d, yaw_q, yaw_d, ay_q, ay_d, az_q, az_d;
    logic        int_q, int_d, overrun_q, overrun_d;

    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [15:0] frame;
    logic        frame_done, unused_abort, miso;
    logic        wr_en, clr_int, armed, accept;

    spi_slv_shift #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shift (
        .clk           (clk),
        .rst           (rst),
        .ss_n_i        (bus.SS_n),
        .sclk_i        (bus.SCLK),
        .mosi_i        (bus.MOSI),
        .rd_data_i     (rd_data),
        .rd_addr_o     (rd_addr),
        .miso_o        (miso),
        .frame_o       (frame),
        .frame_done_o  (frame_done),
        .frame_abort_o (unused_abort)
    );

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_INT_CFG: rd_data = int_cfg_q;
            ADDR_CTRL1:   rd_data = ctrl1_q;
            ADDR_CTRL2:   rd_data = ctrl2_q;
            ADDR_CTRL3:   rd_data = ctrl3_q;
            ADDR_ROLL_L:  rd_data = roll_q[7:0];
            ADDR_ROLL_H:  rd_data = roll_q[15:8];
            ADDR_YAW_L:   rd_data = yaw_q[7:0];
            ADDR_YAW_H:   rd_data = yaw_q[15:8];
            ADDR_AY_L:    rd_data = ay_q[7:0];
            ADDR_AY_H:    rd_data = ay_q[15:8];
            ADDR_AZ_L:    rd_data = az_q[7:0];
            ADDR_AZ_H:    rd_data = az_q[15:8];
            default:      rd_data = 8'h00;
        endcase
    end

    assign wr_en   = frame_done & ~frame[READ_BIT];
    assign clr_int = frame_done & frame[READ_BIT] & (frame[14:8] == ADDR_AZ_H);
    assign armed   = int_cfg_q[1] & (ctrl1_q != 8'h00) & (ctrl2_q != 8'h00);
    // A read of AZ_H committing in the same cycle frees the latch for this sample.
    assign accept  = bus.smpl_vld & armed & (~int_q | clr_int);

    // Register writes, sample latch, INT and sticky overrun.
    always_comb begin
        int_cfg_d = int_cfg_q;
        ctrl1_d   = ctrl1_q;
        ctrl2_d   = ctrl2_q;
        ctrl3_d   = ctrl3_q;
        roll_d    = roll_q;
        yaw_d     = yaw_q;
        ay_d      = ay_q;
        az_d      = az_q;
        int_d     = int_q;
        overrun_d = overrun_q;
        if (wr_en) begin
            case (frame[14:8])
                ADDR_INT_CFG: int_cfg_d = frame[7:0];
                ADDR_CTRL1:   ctrl1_d   = frame[7:0];
                ADDR_CTRL2:   ctrl2_d   = frame[7:0];
                ADDR_CTRL3:   ctrl3_d   = frame[7:0];
                default: ;
            endcase
        end
        if (clr_int) begin
            int_d = 1'b0;
        end
        if (accept) begin
            roll_d = bus.roll_rt_in;
            yaw_d  = bus.yaw_rt_in;
            ay_d   = bus.AY_in;
            az_d   = bus.AZ_in;
            int_d  = 1'b1;
        end
        if (bus.smpl_vld && armed && int_q && !clr_int) begin
            overrun_d = 1'b1;
        end
    end

    // Register file state.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_cfg_q <= '0;
            ctrl1_q   <= '0;
            ctrl2_q   <= '0;
            ctrl3_q   <= '0;
            roll_q    <= '0;
            yaw_q     <= '0;
            ay_q      <= '0;
            az_q      <= '0;
            int_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            int_cfg_q <= int_cfg_d;
            ctrl1_q   <= ctrl1_d;
            ctrl2_q   <= ctrl2_d;
            ctrl3_q   <= ctrl3_d;
            roll_q    <= roll_d;
            yaw_q     <= yaw_d;
            ay_q      <= ay_d;
            az_q      <= az_d;
            int_q     <= int_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.MISO    = miso;
    assign bus.INT     = int_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_inert_spi_slave.sv
// Directed self-checking bench for inert_spi_slave.
module tb_inert_spi_slave;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    inert_spi_slave_if bus ();

    inert_spi_slave #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic spi_begin();
        bus.SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // Clocks bits first..last of word (MSB first); collects MISO for bits 8..15.
    task automatic spi_bits(input logic [15:0] word, input int first, input int last,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = first; i <= last; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = word[15-i];
            repeat (HALF) @(negedge clk);
            if (i >= 8) rx = {rx[6:0], bus.MISO};
            bus.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic spi_frame(input logic [15:0] word, output logic [7:0] rx);
        spi_begin();
        spi_bits(word, 0, 15, rx);
        bus.SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic set_sample(input logic [15:0] r, input logic [15:0] y,
                              input logic [15:0] a, input logic [15:0] z);
        bus.roll_rt_in = r;
        bus.yaw_rt_in  = y;
        bus.AY_in      = a;
        bus.AZ_in      = z;
    endtask

    task automatic test_reset();
        logic [7:0] b;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.MISO !== 1'b0) begin bad++; $display("FAIL reset_miso got %b want 0", bus.MISO); end
        total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL reset_int got %b want 0", bus.INT); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got %b want 0", bus.overrun); end
        spi_frame(16'h8D00, b);
        total++; if (b !== 8'h00) begin bad++; $display("FAIL reset_int_cfg got %h want 00", b); end
    endtask

    task automatic test_config();
        logic [7:0] b;
        spi_frame(16'h0D02, b);
        spi_frame(16'h1053, b);
        spi_frame(16'h1150, b);
        spi_frame(16'h1460, b);
        spi_frame(16'h8D00, b);
        total++; if (b !== 8'h02) begin bad++; $display("FAIL cfg_int_cfg got %h want 02", b); end
        spi_frame(16'h9000, b);
        total++; if (b !== 8'h53) begin bad++; $display("FAIL cfg_ctrl1 got %h want 53", b); end
        spi_frame(16'h9400, b);
        total++; if (b !== 8'h60) begin bad++; $display("FAIL cfg_ctrl3 got %h want 60", b); end
        total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL cfg_int got %b want 0", bus.INT); end
    endtask

    task automatic test_sample_read();
        logic [7:0]  b;
        logic [15:0] cmds [8] = '{16'hA400, 16'hA500, 16'hA600, 16'hA700,
                                  16'hAA00, 16'hAB00, 16'hAC00, 16'hAD00};
        logic [7:0]  exps [8] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h0F, 8'h01, 8'h80};
        set_sample(16'h1234, 16'hABCD, 16'h0F00, 16'h8001);
        bus.smpl_vld = 1'b1;
        total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL smpl_int_before got %b want 0", bus.INT); end
        @(negedge clk);
        bus.smpl_vld = 1'b0;
        total++; if (bus.INT !== 1'b1) begin bad++; $display("FAIL smpl_int_after got %b want 1", bus.INT); end
        for (int i = 0; i < 7; i++) begin
            spi_frame(cmds[i], b);
            total++;
            if (b !== exps[i]) begin
                bad++; $display("FAIL rd_%h got %h want %h", cmds[i][15:8], b, exps[i]);
            end
        end
        total++; if (bus.INT !== 1'b1) begin bad++; $display("FAIL int_held got %b want 1", bus.INT); end
        spi_begin();
        spi_bits(cmds[7], 0, 15, b);
        bus.SS_n = 1'b1;
        total++; if (b !== exps[7]) begin bad++; $display("FAIL rd_ad got %h want %h", b, exps[7]); end
        repeat (SYNC_STAGES + 1) @(negedge clk);
        total++; if (bus.INT !== 1'b1) begin bad++; $display("FAIL int_pre_commit got %b want 1", bus.INT); end
        @(negedge clk);
        total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL int_cleared got %b want 0", bus.INT); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_concurrent_and_overrun();
        logic [7:0] b;
        set_sample(16'h5566, 16'h0000, 16'h0000, 16'h4321);
        bus.smpl_vld = 1'b1;
        @(negedge clk);
        bus.smpl_vld = 1'b0;
        // sample 3 lands in the same cycle as the AZ_H read commit
        spi_begin();
        spi_bits(16'hAD00, 0, 15, b);
        bus.SS_n = 1'b1;
        total++; if (b !== 8'h43) begin bad++; $display("FAIL conc_rd got %h want 43", b); end
        repeat (SYNC_STAGES + 1) @(negedge clk);
        set_sample(16'h7788, 16'h1111, 16'h2222, 16'h99AA);
        bus.smpl_vld = 1'b1;
        @(negedge clk);
        bus.smpl_vld = 1'b0;
        total++; if (bus.INT !== 1'b1) begin bad++; $display("FAIL conc_int got %b want 1", bus.INT); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL conc_ovr got %b want 0", bus.overrun); end
        repeat (6) @(negedge clk);
        spi_frame(16'hA400, b);
        total++; if (b !== 8'h88) begin bad++; $display("FAIL conc_data got %h want 88", b); end
        // sample 4 arrives while INT is still set
        set_sample(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
        bus.smpl_vld = 1'b1;
        @(negedge clk);
        bus.smpl_vld = 1'b0;
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got %b want 1", bus.overrun); end
        spi_frame(16'hA400, b);
        total++; if (b !== 8'h88) begin bad++; $display("FAIL ovr_frozen got %h want 88", b); end
        spi_frame(16'hAD00, b);
        total++; if (b !== 8'h99) begin bad++; $display("FAIL ovr_az_h got %h want 99", b); end
        total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL ovr_int_clr got %b want 0", bus.INT); end
    endtask

    task automatic test_abort_unmapped();
        logic [7:0] b;
        spi_begin();
        spi_bits(16'h0D00, 0, 9, b);
        bus.SS_n = 1'b1;
        repeat (8) @(negedge clk);
        spi_frame(16'h8D00, b);
        total++; if (b !== 8'h02) begin bad++; $display("FAIL abort_int_cfg got %h want 02", b); end
        set_sample(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        bus.smpl_vld = 1'b1;
        @(negedge clk);
        bus.smpl_vld = 1'b0;
        total++; if (bus.INT !== 1'b1) begin bad++; $display("FAIL abort_int got %b want 1", bus.INT); end
        spi_frame(16'hFF00, b);
        total++; if (b !== 8'h00) begin bad++; $display("FAIL unmapped got %h want 00", b); end
    endtask

    task automatic test_rst_mid_frame();
        logic [7:0] b;
        spi_begin();
        spi_bits(16'h10AA, 0, 8, b);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.MISO !== 1'b0) begin bad++; $display("FAIL rst_miso got %b want 0", bus.MISO); end
        total++; if (bus.INT !== 1'b0) begin bad++; $display("FAIL rst_int got %b want 0", bus.INT); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr got %b want 0", bus.overrun); end
        spi_bits(16'h10AA, 9, 15, b);
        bus.SS_n = 1'b1;
        repeat (8) @(negedge clk);
        spi_frame(16'h9000, b);
        total++; if (b !== 8'h00) begin bad++; $display("FAIL rst_ctrl1 got %h want 00", b); end
        spi_frame(16'h8D00, b);
        total++; if (b !== 8'h00) begin bad++; $display("FAIL rst_int_cfg got %h want 00", b); end
        spi_frame(16'hA400, b);
        total++; if (b !== 8'h00) begin bad++; $display("FAIL rst_roll got %h want 00", b); end
        spi_frame(16'h1077, b);
        spi_frame(16'h9000, b);
        total++; if (b !== 8'h77) begin bad++; $display("FAIL rst_rewrite got %h want 77", b); end
    endtask

    initial begin
        bus.SS_n     = 1'b1;
        bus.SCLK     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.smpl_vld = 1'b0;
        set_sample(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        test_reset();
        test_config();
        test_sample_read();
        test_concurrent_and_overrun();
        test_abort_unmapped();
        test_rst_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
